// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM leaf slave with wait states, byte-lane writes, ERROR responses and write forwarding.
// Latency: read data is valid 1 cycle after the address phase, or WAIT_STATES+1 cycles with waits. A write commits one edge after HWDATA capture.
// Backpressure: HREADYOUT is low for WAIT_STATES cycles in each OKAY data phase and for the first cycle of an ERROR.
// Optional: define AHB_SRAM_STATS_EN to add the rd_cnt/wr_cnt/err_cnt saturating transfer counters.
module ahb_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
`ifdef AHB_SRAM_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = ADDR_W - LB;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t            state;
  logic [2:0]        cnt;

  // Data-phase context of the transfer accepted on the last address phase
  logic              dp_vld;
  logic              dp_write;
  logic [IW-1:0]     dp_idx;
  logic [NB-1:0]     dp_strb;

  // One-entry write buffer between HWDATA capture and the array write
  logic              wb_vld;
  logic [IW-1:0]     wb_idx;
  logic [DATA_W-1:0] wb_dat;
  logic [NB-1:0]     wb_strb;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LB-1:0]     a_off;
  logic [IW-1:0]     a_idx;
  logic              a_err;
  logic [NB-1:0]     a_strb;
  logic              accept;
  logic              wr_capture;
  logic              rd_load;
  logic [IW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              unused;

  assign a_off  = HADDR[LB-1:0];
  assign a_idx  = HADDR[ADDR_W-1:LB];
  assign unused = HTRANS[0];

  // Only IDLE and ERR2 end with HREADYOUT high, so only they can take a new address phase
  assign accept = HSEL & HTRANS[1] & HREADY & ((state == IDLE) | (state == ERR2));

  // The final data cycle of an OKAY transfer is always spent in IDLE
  assign wr_capture = (state == IDLE) & dp_vld & dp_write;

  // Address-phase checks (range, size, alignment) and byte-lane strobes
  always_comb begin
    a_err  = 1'b0;
    a_strb = '0;
    if (32'(a_idx) >= DEPTH) a_err = 1'b1;
    if (HSIZE > 3'(LB)) a_err = 1'b1;
    for (int i = 0; i < LB; i++) begin
      if ((i < int'(HSIZE)) && a_off[i]) a_err = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(a_off)) && (b < int'(a_off) + (1 << HSIZE))) a_strb[b] = 1'b1;
    end
  end

  // Pick when and where HRDATA is loaded: the edge entering the final data cycle
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = a_idx;
    if (WAIT_STATES == 0) begin
      rd_load = accept & ~a_err & ~HWRITE;
      rd_idx  = a_idx;
    end else begin
      rd_load = (state == WAIT) && (cnt == 3'd0) && dp_vld && !dp_write;
      rd_idx  = dp_idx;
    end
  end

  // Read word with buffered and same-edge writes merged in, oldest first
  always_comb begin
    rd_word = mem[rd_idx[MW-1:0]];
    if (wb_vld && (wb_idx == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_strb[b]) rd_word[b*8 +: 8] = wb_dat[b*8 +: 8];
      end
    end
    if (wr_capture && (dp_idx == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (dp_strb[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP and data-phase context
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      dp_vld    <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      dp_strb   <= '0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          if (accept) begin
            dp_vld   <= ~a_err;
            dp_write <= HWRITE;
            dp_idx   <= a_idx;
            dp_strb  <= a_strb;
            if (a_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state     <= WAIT;
              cnt       <= 3'(WAIT_STATES - 1);
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
            end else begin
              state     <= IDLE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
            end
          end else begin
            dp_vld    <= 1'b0;
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

  // Capture HWDATA at the end of a write data phase; reset drops an uncommitted entry
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wb_vld  <= 1'b0;
      wb_idx  <= '0;
      wb_dat  <= '0;
      wb_strb <= '0;
    end else begin
      wb_vld <= wr_capture;
      if (wr_capture) begin
        wb_idx  <= dp_idx;
        wb_dat  <= HWDATA;
        wb_strb <= dp_strb;
      end
    end
  end

  // Commit the buffered write to the array, byte lane by byte lane
  always_ff @(posedge HCLK) begin
    if (wb_vld) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_strb[b]) mem[wb_idx[MW-1:0]][b*8 +: 8] <= wb_dat[b*8 +: 8];
      end
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) HRDATA <= '0;
    else if (rd_load) HRDATA <= rd_word;
  end

`ifdef AHB_SRAM_STATS_EN
  // Saturating counts of completed OKAY reads, OKAY writes and ERROR transfers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_cnt  <= 16'd0;
      wr_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      if ((state == IDLE) && dp_vld && !dp_write && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (wr_capture && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      if ((state == ERR2) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
